// File: rtl/kv_wb_frontend_if.sv
// Bundle of the Wishbone slave bus and the core command/response channels
// for the key-value store front-end. The slave modport is the front-end's
// view; the master modport is the SoC/core side driving it.
interface kv_wb_frontend_if #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 32
);
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic [VAL_W-1:0] cmd_value;

  logic             rsp_valid;
  logic             rsp_found;
  logic             rsp_full;
  logic [VAL_W-1:0] rsp_value;

  logic             irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output cmd_valid, cmd_op, cmd_key, cmd_value,
    input  cmd_ready,
    input  rsp_valid, rsp_found, rsp_full, rsp_value,
    output irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  cmd_valid, cmd_op, cmd_key, cmd_value,
    output cmd_ready,
    output rsp_valid, rsp_found, rsp_full, rsp_value,
    input  irq_o
  );
endinterface

// File: rtl/kv_wb_frontend.sv
// Wishbone slave front-end for the key-value store core. Holds the
// KEY/VALUE/CMD/STATUS/RESULT register file, launches one command at a
// time to the core over a valid/ready channel and captures the single-beat
// response into STATUS/RESULT, raising a level interrupt when enabled.
module kv_wb_frontend #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_W     = 32,
  parameter int          VAL_W     = 32
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  kv_wb_frontend_if.slave   bus
);

  localparam logic [7:0] OFF_KEY    = 8'h00;
  localparam logic [7:0] OFF_VALUE  = 8'h04;
  localparam logic [7:0] OFF_CMD    = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;

  localparam logic [1:0] OP_GET = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             full_q, full_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             ie_q, ie_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_op_q, cmd_op_d;
  logic [KEY_W-1:0] cmd_key_q, cmd_key_d;
  logic [VAL_W-1:0] cmd_value_q, cmd_value_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             irq_q, irq_d;

  logic        in_window;
  logic        req;
  logic        wr_req;
  logic        rd_req;
  logic [7:0]  offset;
  logic [31:0] wmask;
  logic [31:0] key_ext;
  logic [31:0] value_ext;
  logic [31:0] result_ext;
  logic [31:0] status_word;
  logic [31:0] rdata;
  logic        busy;

  assign in_window  = (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req        = bus.wbs_cyc_i & bus.wbs_stb_i & in_window & ~ack_q;
  assign wr_req     = req & bus.wbs_we_i;
  assign rd_req     = req & ~bus.wbs_we_i;
  assign offset     = bus.wbs_adr_i[7:0];
  assign wmask      = {{8{bus.wbs_sel_i[3]}}, {8{bus.wbs_sel_i[2]}},
                       {8{bus.wbs_sel_i[1]}}, {8{bus.wbs_sel_i[0]}}};
  assign key_ext    = 32'(key_q);
  assign value_ext  = 32'(value_q);
  assign result_ext = 32'(result_q);
  assign busy       = (state_q != ST_IDLE);
  assign status_word = {23'd0, ie_q, 3'd0, overrun_q, done_q, full_q, found_q, busy};

  // Read mux over the register file; unmapped and write-only offsets read 0.
  always_comb begin
    rdata = 32'd0;
    case (offset)
      OFF_KEY:    rdata = key_ext;
      OFF_VALUE:  rdata = value_ext;
      OFF_STATUS: rdata = status_word;
      OFF_RESULT: rdata = result_ext;
      default:    rdata = 32'd0;
    endcase
  end

  // Next-state logic: bus access side effects first, then the command FSM,
  // so that a response setting done overrides a same-cycle W1C of done.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    value_d     = value_q;
    result_d    = result_q;
    found_d     = found_q;
    full_d      = full_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    ie_d        = ie_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_key_d   = cmd_key_q;
    cmd_value_d = cmd_value_q;
    ack_d       = req;
    dat_d       = rd_req ? rdata : 32'd0;
    irq_d       = done_q & ie_q;

    if (wr_req) begin
      case (offset)
        OFF_KEY:   key_d   = KEY_W'((key_ext & ~wmask) | (bus.wbs_dat_i & wmask));
        OFF_VALUE: value_d = VAL_W'((value_ext & ~wmask) | (bus.wbs_dat_i & wmask));
        OFF_CMD: begin
          if (bus.wbs_dat_i[1:0] != 2'd0) begin
            if (state_q == ST_IDLE) begin
              cmd_op_d    = bus.wbs_dat_i[1:0];
              cmd_key_d   = key_q;
              cmd_value_d = value_q;
              cmd_valid_d = 1'b1;
              found_d     = 1'b0;
              full_d      = 1'b0;
              state_d     = ST_ISSUE;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        OFF_STATUS: begin
          if (bus.wbs_sel_i[0]) begin
            if (bus.wbs_dat_i[3]) done_d    = 1'b0;
            if (bus.wbs_dat_i[4]) overrun_d = 1'b0;
          end
          if (bus.wbs_sel_i[1]) ie_d = bus.wbs_dat_i[8];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_ISSUE: begin
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.rsp_valid) begin
          found_d = bus.rsp_found;
          full_d  = bus.rsp_full;
          if (cmd_op_q == OP_GET) result_d = bus.rsp_value;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      value_q     <= '0;
      result_q    <= '0;
      found_q     <= 1'b0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ie_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 2'd0;
      cmd_key_q   <= '0;
      cmd_value_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      value_q     <= value_d;
      result_q    <= result_d;
      found_q     <= found_d;
      full_q      <= full_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      ie_q        <= ie_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_key_q   <= cmd_key_d;
      cmd_value_q <= cmd_value_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_key   = cmd_key_q;
  assign bus.cmd_value = cmd_value_q;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_kv_wb_frontend.sv
// Testbench for kv_wb_frontend: directed register/command sequences with a
// scoreboard of expected read data and expected core commands, checked by
// a separate monitor whenever the DUT acks a read or hands off a command.
module tb_kv_wb_frontend;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          KEY_W = 32;
  localparam int          VAL_W = 32;

  localparam logic [7:0] R_KEY    = 8'h00;
  localparam logic [7:0] R_VALUE  = 8'h04;
  localparam logic [7:0] R_CMD    = 8'h08;
  localparam logic [7:0] R_STATUS = 8'h0C;
  localparam logic [7:0] R_RESULT = 8'h10;

  typedef struct {
    logic [31:0] data;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] value;
  } cmd_exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   hs_count;
  int   hs_before;
  logic acked;

  rd_exp_t  rd_q[$];
  cmd_exp_t cmd_q[$];

  kv_wb_frontend_if #(.KEY_W(KEY_W), .VAL_W(VAL_W)) bus ();

  kv_wb_frontend #(
    .BASE_ADDR(BASE),
    .KEY_W    (KEY_W),
    .VAL_W    (VAL_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and keep the counts
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // One Wishbone classic access; waits up to max_cycles for the ack
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [3:0] sel, input logic [31:0] data,
                               input int max_cycles, output logic got_ack);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = addr;
    bus.wbs_dat_i = data;
    got_ack = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        got_ack = 1'b1;
        break;
      end
    end
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'd0;
  endtask

  task automatic wbWrite(input logic [7:0] off, input logic [31:0] data,
                         input logic [3:0] sel = 4'hF);
    logic a;
    applyStimulus(BASE | 32'(off), 1'b1, sel, data, 8, a);
    checkOutput("write ack", 32'(a), 32'd1);
  endtask

  task automatic wbRead(input logic [7:0] off, input logic [31:0] exp,
                        input string name);
    logic a;
    rd_exp_t e;
    e.data = exp;
    e.name = name;
    rd_q.push_back(e);
    applyStimulus(BASE | 32'(off), 1'b0, 4'hF, 32'd0, 8, a);
    checkOutput({name, " ack"}, 32'(a), 32'd1);
  endtask

  task automatic expectCmd(input logic [1:0] op, input logic [31:0] key,
                           input logic [31:0] value);
    cmd_exp_t c;
    c.op    = op;
    c.key   = key;
    c.value = value;
    cmd_q.push_back(c);
  endtask

  // Drive a one-cycle response from the current (negedge) time
  task automatic respond(input logic found, input logic full, input logic [31:0] value);
    bus.rsp_valid = 1'b1;
    bus.rsp_found = found;
    bus.rsp_full  = full;
    bus.rsp_value = value;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_found = 1'b0;
    bus.rsp_full  = 1'b0;
    bus.rsp_value = 32'd0;
  endtask

  // Monitor: pops the scoreboard on every read ack and every command handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wbs_ack_o && !bus.wbs_we_i) begin
          if (rd_q.size() == 0) begin
            checkOutput("unexpected read ack", 32'd1, 32'd0);
          end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            checkOutput(e.name, bus.wbs_dat_o, e.data);
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          hs_count++;
          if (cmd_q.size() == 0) begin
            checkOutput("unexpected handshake", 32'd1, 32'd0);
          end else begin
            cmd_exp_t c;
            c = cmd_q.pop_front();
            checkOutput("cmd_op", 32'(bus.cmd_op), 32'(c.op));
            checkOutput("cmd_key", bus.cmd_key, c.key);
            checkOutput("cmd_value", bus.cmd_value, c.value);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    hs_count      = 0;
    rst           = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'd0;
    bus.wbs_dat_i = 32'd0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_found = 1'b0;
    bus.rsp_full  = 1'b0;
    bus.rsp_value = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst ack", 32'(bus.wbs_ack_o), 32'd0);
    checkOutput("rst dat", bus.wbs_dat_o, 32'd0);
    checkOutput("rst cmd_valid", 32'(bus.cmd_valid), 32'd0);
    checkOutput("rst cmd_op", 32'(bus.cmd_op), 32'd0);
    checkOutput("rst cmd_key", bus.cmd_key, 32'd0);
    checkOutput("rst cmd_value", bus.cmd_value, 32'd0);
    checkOutput("rst irq", 32'(bus.irq_o), 32'd0);
    rst = 1'b0;

    // Reset mid-ISSUE
    wbWrite(R_KEY, 32'h99);
    wbWrite(R_CMD, 32'd1);
    checkOutput("issue cmd_valid", 32'(bus.cmd_valid), 32'd1);
    #2 rst = 1'b1;
    #1 checkOutput("async drop cmd_valid", 32'(bus.cmd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    respond(1'b1, 1'b1, 32'hDEAD_BEEF);
    wbRead(R_STATUS, 32'h000, "status after reset");
    wbRead(R_KEY, 32'h0, "key after reset");
    wbRead(R_RESULT, 32'h0, "result after stray rsp");

    // PUT then GET, ready tied high
    bus.cmd_ready = 1'b1;
    wbWrite(R_KEY, 32'h1234);
    wbWrite(R_VALUE, 32'hCAFE_BABE);
    expectCmd(2'd1, 32'h1234, 32'hCAFE_BABE);
    wbWrite(R_CMD, 32'd1);
    checkOutput("put valid", 32'(bus.cmd_valid), 32'd1);
    @(negedge clk);
    checkOutput("put one-cycle valid", 32'(bus.cmd_valid), 32'd0);
    respond(1'b0, 1'b0, 32'd0);
    wbRead(R_STATUS, 32'h008, "status after put");
    expectCmd(2'd2, 32'h1234, 32'hCAFE_BABE);
    wbWrite(R_CMD, 32'd2);
    @(negedge clk);
    respond(1'b1, 1'b0, 32'hCAFE_BABE);
    wbRead(R_RESULT, 32'hCAFE_BABE, "result after get");
    wbRead(R_STATUS, 32'h00A, "status after get");
    wbRead(R_CMD, 32'h0, "cmd reads zero");

    // Backpressure and overrun
    wbWrite(R_STATUS, 32'h18);
    bus.cmd_ready = 1'b0;
    wbWrite(R_KEY, 32'h55);
    wbWrite(R_VALUE, 32'h66);
    expectCmd(2'd1, 32'h55, 32'h66);
    wbWrite(R_CMD, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp cmd_valid", 32'(bus.cmd_valid), 32'd1);
      checkOutput("bp cmd_op", 32'(bus.cmd_op), 32'd1);
      checkOutput("bp cmd_key", bus.cmd_key, 32'h55);
    end
    wbRead(R_STATUS, 32'h001, "status busy");
    wbWrite(R_KEY, 32'h77);
    wbWrite(R_CMD, 32'd2);
    checkOutput("bp key held", bus.cmd_key, 32'h55);
    wbRead(R_STATUS, 32'h011, "status overrun");
    hs_before = hs_count;
    @(posedge clk);
    #1 bus.cmd_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("single handshake", 32'(hs_count - hs_before), 32'd1);
    respond(1'b0, 1'b0, 32'd0);
    wbRead(R_STATUS, 32'h018, "status done+overrun");
    wbWrite(R_STATUS, 32'h18);
    wbRead(R_STATUS, 32'h000, "status cleared");
    wbRead(R_KEY, 32'h77, "key written while busy");

    // Full store; response and W1C of done land on the same edge
    expectCmd(2'd1, 32'h77, 32'h66);
    wbWrite(R_CMD, 32'd1);
    fork
      begin
        @(negedge clk);
        respond(1'b0, 1'b1, 32'd0);
      end
      applyStimulus(BASE | 32'(R_STATUS), 1'b1, 4'hF, 32'h08, 8, acked);
    join
    checkOutput("w1c race ack", 32'(acked), 32'd1);
    wbRead(R_STATUS, 32'h00C, "status full set-wins");
    wbWrite(R_STATUS, 32'h08);
    wbRead(R_STATUS, 32'h004, "status full after w1c");

    // Interrupt
    wbWrite(R_STATUS, 32'h100);
    expectCmd(2'd3, 32'h77, 32'h66);
    wbWrite(R_CMD, 32'd3);
    @(negedge clk);
    respond(1'b1, 1'b0, 32'd0);
    checkOutput("irq not yet", 32'(bus.irq_o), 32'd0);
    @(negedge clk);
    checkOutput("irq raised", 32'(bus.irq_o), 32'd1);
    wbRead(R_STATUS, 32'h10A, "status del ie");
    wbWrite(R_STATUS, 32'h108);
    checkOutput("irq before drop", 32'(bus.irq_o), 32'd1);
    @(negedge clk);
    checkOutput("irq dropped", 32'(bus.irq_o), 32'd0);
    wbRead(R_STATUS, 32'h102, "status after irq clear");

    // Address decode and byte enables
    applyStimulus(BASE + 32'h100, 1'b1, 4'hF, 32'hFFFF_FFFF, 8, acked);
    checkOutput("out-of-window write ack", 32'(acked), 32'd0);
    applyStimulus(BASE + 32'h100, 1'b0, 4'hF, 32'd0, 8, acked);
    checkOutput("out-of-window read ack", 32'(acked), 32'd0);
    wbRead(R_KEY, 32'h77, "key unchanged by outside write");
    wbRead(8'h20, 32'h0, "unmapped read");
    wbWrite(8'h14, 32'hFFFF_FFFF);
    wbWrite(R_KEY, 32'h0);
    wbWrite(R_KEY, 32'h1234_AA56, 4'b0010);
    wbRead(R_KEY, 32'h0000_AA00, "byte write key");

    repeat (5) @(negedge clk);
    checkOutput("read scoreboard drained", 32'(rd_q.size()), 32'd0);
    checkOutput("cmd scoreboard drained", 32'(cmd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
